final_project_button_in_pio: RTL and testbench

Avalon-MM slave input port with debounce, edge capture and interrupt generation. It carries board push-button and switch levels from the FPGA pins into the Nios II software. It is the read-direction counterpart of the project's output PIOs: hardware drives `in_port` and the CPU reads it. Sits on the same system interconnect as the output PIOs, with zero wait states and read latency 0.

---
 rtl/final_project_button_in_pio.sv | 87 ++++++++
 tb/tb_final_project_button_in_pio.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/final_project_button_in_pio.sv
// Avalon-MM input PIO: two-flop synchronizer, whole-vector debounce, edge capture
// with write-1-to-clear, and a masked level interrupt.
module final_project_button_in_pio #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_s1, r_s, r_cand, r_deb, r_deb_d, r_irq_mask, r_edge_capture;
   logic [CW-1:0]    r_cnt;
   logic             w_wr;
   logic [WIDTH-1:0] w_clr, w_new_edges;
   logic             w_unused_wdata;

   assign w_wr  = chipselect & ~write_n;
   assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
   assign w_unused_wdata = ^writedata;

   always_comb begin
      case (EDGE_TYPE)
         0:       w_new_edges = r_deb & ~r_deb_d;
         1:       w_new_edges = ~r_deb & r_deb_d;
         default: w_new_edges = r_deb ^ r_deb_d;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1  <= '0;
         r_s   <= '0;
         r_cand <= '0;
         r_cnt <= '0;
         r_deb <= '0;
         r_deb_d <= '0;
      end else begin
         r_s1 <= in_port;
         r_s  <= r_s1;
         r_deb_d <= r_deb;
         // Any bit moving restarts the count for the whole vector.
         if (r_s != r_cand) begin
            r_cand <= r_s;
            r_cnt  <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_cand;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq_mask     <= '0;
         r_edge_capture <= '0;
      end else begin
         if (w_wr && address == 2'd2) r_irq_mask <= writedata[WIDTH-1:0];
         // New edges are OR-ed in after the clear so a same-cycle edge survives.
         r_edge_capture <= (r_edge_capture & ~w_clr) | w_new_edges;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = r_deb;
         2'd2:    readdata[WIDTH-1:0] = r_irq_mask;
         2'd3:    readdata[WIDTH-1:0] = r_edge_capture;
         default: readdata = '0;
      endcase
   end

   assign irq = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_final_project_button_in_pio.sv
// Directed bench for the input PIO; expectations are queued by stimulus and
// checked by a separate monitor on the falling clock edge.
module tb_final_project_button_in_pio;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  in_port = '0;
   logic        irq;

   typedef struct {
      bit          is_irq;
      string       name;
      logic [31:0] exp;
   } chk_t;

   chk_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   final_project_button_in_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .irq(irq)
   );

   always #5 clk = ~clk;

   // Monitor: drain every expectation queued for this cycle.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t e;
         logic [31:0] act;
         e = q.pop_front();
         act = e.is_irq ? {31'd0, irq} : readdata;
         n_chk++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", e.name, act, e.exp, $time);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_rd(input logic [1:0] a, input logic [31:0] v, input string nm);
      chk_t e;
      address = a;
      e.is_irq = 1'b0; e.name = nm; e.exp = v;
      q.push_back(e);
   endtask

   task automatic exp_irq(input logic v, input string nm);
      chk_t e;
      e.is_irq = 1'b1; e.name = nm; e.exp = {31'd0, v};
      q.push_back(e);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b0;

      // Reset state: every address reads 0, irq low for 100 cycles.
      for (int a = 0; a < 4; a++) begin
         exp_rd(a[1:0], 32'h0, "reset_read");
         exp_irq(1'b0, "reset_irq");
         tick();
      end
      for (int k = 0; k < 96; k++) begin
         exp_irq(1'b0, "idle_irq");
         tick();
      end

      // Writes to addresses 0 and 1 have no effect.
      wr(2'd0, 32'hFF);
      wr(2'd1, 32'hFF);
      exp_rd(2'd0, 32'h0, "wr_addr0_ignored"); tick();
      exp_rd(2'd1, 32'h0, "wr_addr1_ignored"); tick();

      // Debounce latency: 0x05 appears at addr 0 after E18, captured after E19.
      wr(2'd2, 32'hFF);
      exp_rd(2'd2, 32'hFF, "mask_rd"); tick();
      in_port = 8'h05;
      tick();  // E0
      for (int k = 0; k <= 19; k++) begin
         if (k <= 18) exp_rd(2'd0, (k >= 18) ? 32'h05 : 32'h0, "latency_deb");
         else         exp_rd(2'd3, 32'h05, "latency_capture");
         exp_irq(k >= 19, "latency_irq");
         tick();
      end

      // Write-1-to-clear.
      wr(2'd3, 32'h01);
      exp_rd(2'd3, 32'h04, "w1c_partial"); exp_irq(1'b1, "w1c_partial_irq"); tick();
      wr(2'd3, 32'h04);
      exp_rd(2'd3, 32'h00, "w1c_full"); exp_irq(1'b0, "w1c_full_irq"); tick();

      // Falling edges are not captured in rising mode; then a 10-cycle glitch.
      in_port = 8'h00;
      for (int k = 0; k < 22; k++) begin exp_irq(1'b0, "fall_irq"); tick(); end
      exp_rd(2'd0, 32'h0, "fall_deb"); tick();
      exp_rd(2'd3, 32'h0, "fall_capture"); tick();
      in_port = 8'h01;
      repeat (10) tick();
      in_port = 8'h00;
      for (int k = 0; k < 30; k++) begin
         exp_rd(k[0] ? 2'd3 : 2'd0, 32'h0, "glitch_rd");
         exp_irq(1'b0, "glitch_irq");
         tick();
      end

      // Same-cycle clear and new edge on bit 2: set wins.
      in_port = 8'h04;
      tick();  // E0
      for (int k = 0; k <= 17; k++) begin exp_rd(2'd3, 32'h0, "setwin_pre"); tick(); end
      address = 2'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
      exp_rd(2'd3, 32'h0, "setwin_before_edge");
      tick();  // E19: edge lands with the clear
      chipselect = 1'b0; write_n = 1'b1;
      exp_rd(2'd3, 32'h04, "setwin_capture"); exp_irq(1'b1, "setwin_irq"); tick();
      wr(2'd3, 32'h04);
      exp_rd(2'd3, 32'h0, "setwin_cleared"); tick();

      // Mask effects, then asynchronous reset while irq is high.
      wr(2'd2, 32'h00);
      in_port = 8'h05;
      for (int k = 0; k < 22; k++) begin exp_irq(1'b0, "masked_irq"); tick(); end
      exp_rd(2'd3, 32'h01, "masked_capture"); exp_irq(1'b0, "masked_irq2"); tick();
      exp_rd(2'd2, 32'h00, "mask_zero"); tick();
      wr(2'd2, 32'h01);
      exp_irq(1'b1, "unmask_irq"); exp_rd(2'd0, 32'h05, "deb_05"); tick();
      wr(2'd2, 32'h00);
      exp_irq(1'b0, "remask_irq"); tick();
      wr(2'd2, 32'h01);
      exp_irq(1'b1, "unmask2_irq"); tick();
      #1 reset = 1'b1;
      #1;
      exp_irq(1'b0, "async_rst_irq"); exp_rd(2'd0, 32'h0, "async_rst_rd0");
      tick();
      exp_rd(2'd1, 32'h0, "rst_rd1"); tick();
      exp_rd(2'd2, 32'h0, "rst_rd2"); tick();
      exp_rd(2'd3, 32'h0, "rst_rd3"); exp_irq(1'b0, "rst_irq"); tick();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
